// File: rtl/rv_regfile_pkg.sv
// Shared widths, types and constants for the 2-read/1-write RISC-V register file.
package rv_regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

  // Storage for x1..x31 only; x0 is never stored.
  typedef logic [NUM_REGS-1:1][DATA_WIDTH-1:0] reg_array_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/rv_regfile_if.sv
// Decode/writeback-facing bus of the register file: one write port, two read ports.
interface rv_regfile_if;
  import rv_regfile_pkg::*;

  reg_data_t wrData;
  reg_idx_t  wrReg;
  logic      writeEnable;
  reg_idx_t  readSelect1;
  reg_idx_t  readSelect2;
  reg_data_t readData1;
  reg_data_t readData2;

  modport master (
    output wrData, wrReg, writeEnable, readSelect1, readSelect2,
    input  readData1, readData2
  );

  modport slave (
    input  wrData, wrReg, writeEnable, readSelect1, readSelect2,
    output readData1, readData2
  );

endinterface

// File: rtl/rv_regfile_rdport.sv
// One combinational read port: select decode, x0 masking and, when
// RV_REGFILE_BYPASS_EN is defined, same-cycle write-to-read forwarding.
module rv_regfile_rdport
  import rv_regfile_pkg::*;
(
  input  reg_array_t i_regs,
  input  reg_idx_t   i_sel,
`ifdef RV_REGFILE_BYPASS_EN
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  reg_idx_t   i_wr_reg,
  input  reg_data_t  i_wr_data,
`endif
  output reg_data_t  o_data
);

  reg_data_t w_stored;

  // Index 0 matches no stored entry, so x0 falls through to the zero default.
  always_comb begin
    // NOTE: default first so every path assigns w_stored and no latch is inferred.
    w_stored = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (i_sel == ADDR_WIDTH'(i)) begin
        w_stored = i_regs[i];
      end
    end
  end

`ifdef RV_REGFILE_BYPASS_EN
  logic w_fwd;

  assign w_fwd  = i_wr_en && !i_rst && (i_wr_reg != ZERO_REG) && (i_wr_reg == i_sel);
  assign o_data = w_fwd ? i_wr_data : w_stored;
`else
  assign o_data = w_stored;
`endif

endmodule

// File: rtl/rv_regfile_2r1w.sv
// 32 x 32-bit RISC-V integer register file, two combinational reads, one synchronous write.
// Optional write-to-read forwarding is enabled by defining RV_REGFILE_BYPASS_EN.
module rv_regfile_2r1w
  import rv_regfile_pkg::*;
(
  input logic         clk,
  input logic         rst,
  rv_regfile_if.slave bus
);

  reg_array_t r_regs;

  always_ff @(posedge clk) begin
    // NOTE: the whole array is reset so unwritten entries never read as X.
    if (rst) begin
      // NOTE: non-blocking assignments so every read this cycle sees pre-edge state.
      r_regs <= '0;
    end else if (bus.writeEnable && (bus.wrReg != ZERO_REG)) begin
      r_regs[bus.wrReg] <= bus.wrData;
    end
  end

  rv_regfile_rdport u_rdport1 (
    .i_regs    (r_regs),
    .i_sel     (bus.readSelect1),
`ifdef RV_REGFILE_BYPASS_EN
    .i_rst     (rst),
    .i_wr_en   (bus.writeEnable),
    .i_wr_reg  (bus.wrReg),
    .i_wr_data (bus.wrData),
`endif
    .o_data    (bus.readData1)
  );

  rv_regfile_rdport u_rdport2 (
    .i_regs    (r_regs),
    .i_sel     (bus.readSelect2),
`ifdef RV_REGFILE_BYPASS_EN
    .i_rst     (rst),
    .i_wr_en   (bus.writeEnable),
    .i_wr_reg  (bus.wrReg),
    .i_wr_data (bus.wrData),
`endif
    .o_data    (bus.readData2)
  );

endmodule

// File: tb/tb_rv_regfile_2r1w.sv
// Directed testbench for rv_regfile_2r1w; expectations follow RV_REGFILE_BYPASS_EN.
module tb_rv_regfile_2r1w;
  import rv_regfile_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rv_regfile_if bus ();

  rv_regfile_2r1w dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance past the next rising edge, leaving time before the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.writeEnable  = 1'b0;
    bus.wrReg        = '0;
    bus.wrData       = '0;
    bus.readSelect1  = '0;
    bus.readSelect2  = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.readSelect1 = ADDR_WIDTH'(i);
      bus.readSelect2 = ADDR_WIDTH'(NUM_REGS - 1 - i);
      #1;
      checks++;
      if (bus.readData1 !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd1 sel=%0d got=%h exp=%h", i, bus.readData1, 32'h0);
      end
      checks++;
      if (bus.readData2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_rd2 sel=%0d got=%h exp=%h", NUM_REGS - 1 - i, bus.readData2, 32'h0);
      end
    end
  endtask

  task automatic test_write_sweep();
    reg_data_t exp1, exp2;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.wrReg       = ADDR_WIDTH'(i);
      bus.wrData      = DATA_WIDTH'(16 * i);
      bus.writeEnable = 1'b1;
      tick();
    end
    bus.writeEnable = 1'b0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      bus.readSelect1 = ADDR_WIDTH'(i);
      bus.readSelect2 = ADDR_WIDTH'(i + 1);
      exp1 = (i == 0) ? 32'h0 : DATA_WIDTH'(16 * i);
      exp2 = DATA_WIDTH'(16 * (i + 1));
      #1;
      checks++;
      if (bus.readData1 !== exp1) begin
        errors++;
        $display("FAIL sweep_rd1 sel=%0d got=%h exp=%h", i, bus.readData1, exp1);
      end
      checks++;
      if (bus.readData2 !== exp2) begin
        errors++;
        $display("FAIL sweep_rd2 sel=%0d got=%h exp=%h", i + 1, bus.readData2, exp2);
      end
    end
  endtask

  task automatic test_x0();
    bus.wrReg       = 5'd0;
    bus.wrData      = 32'hFFFF_FFFF;
    bus.writeEnable = 1'b1;
    bus.readSelect1 = 5'd0;
    bus.readSelect2 = 5'd0;
    #1;
    checks++;
    if (bus.readData1 !== 32'h0) begin
      errors++;
      $display("FAIL x0_no_fwd rd1 got=%h exp=%h", bus.readData1, 32'h0);
    end
    tick();
    bus.writeEnable = 1'b0;
    #1;
    checks++;
    if (bus.readData1 !== 32'h0) begin
      errors++;
      $display("FAIL x0_rd1 got=%h exp=%h", bus.readData1, 32'h0);
    end
    checks++;
    if (bus.readData2 !== 32'h0) begin
      errors++;
      $display("FAIL x0_rd2 got=%h exp=%h", bus.readData2, 32'h0);
    end
  endtask

  task automatic test_write_enable_gate();
    bus.writeEnable = 1'b0;
    bus.wrReg       = 5'd5;
    bus.wrData      = 32'h0000_DEAD;
    bus.readSelect1 = 5'd5;
    bus.readSelect2 = 5'd6;
    tick();
    #1;
    checks++;
    if (bus.readData1 !== 32'd80) begin
      errors++;
      $display("FAIL we_gate_reg5 got=%h exp=%h", bus.readData1, 32'd80);
    end
    checks++;
    if (bus.readData2 !== 32'd96) begin
      errors++;
      $display("FAIL we_gate_reg6 got=%h exp=%h", bus.readData2, 32'd96);
    end
  endtask

  task automatic test_reset_priority();
    rst             = 1'b1;
    bus.writeEnable = 1'b1;
    bus.wrReg       = 5'd7;
    bus.wrData      = 32'd9;
    bus.readSelect1 = 5'd7;
    bus.readSelect2 = 5'd31;
    #1;
    // Before the edge: rst blocks forwarding, so stored contents still show.
    checks++;
    if (bus.readData1 !== 32'd112) begin
      errors++;
      $display("FAIL rst_no_fwd reg7 got=%h exp=%h", bus.readData1, 32'd112);
    end
    tick();
    rst             = 1'b0;
    bus.writeEnable = 1'b0;
    #1;
    checks++;
    if (bus.readData1 !== 32'h0) begin
      errors++;
      $display("FAIL rst_prio reg7 got=%h exp=%h", bus.readData1, 32'h0);
    end
    checks++;
    if (bus.readData2 !== 32'h0) begin
      errors++;
      $display("FAIL rst_prio reg31 got=%h exp=%h", bus.readData2, 32'h0);
    end
  endtask

  task automatic test_same_index();
    int        idx [4] = '{1, 2, 7, 31};
    reg_data_t exp_pre;
    reg_data_t exp_post;
    for (int k = 0; k < 4; k++) begin
      bus.wrReg       = ADDR_WIDTH'(idx[k]);
      bus.readSelect1 = ADDR_WIDTH'(idx[k]);
      bus.readSelect2 = ADDR_WIDTH'(idx[k]);
      bus.wrData      = DATA_WIDTH'(16 * idx[k]);
      bus.writeEnable = 1'b1;
      exp_post        = DATA_WIDTH'(16 * idx[k]);
`ifdef RV_REGFILE_BYPASS_EN
      exp_pre = exp_post;
`else
      exp_pre = 32'h0;
`endif
      #1;
      checks++;
      if (bus.readData1 !== exp_pre) begin
        errors++;
        $display("FAIL same_pre_rd1 idx=%0d got=%h exp=%h", idx[k], bus.readData1, exp_pre);
      end
      checks++;
      if (bus.readData2 !== exp_pre) begin
        errors++;
        $display("FAIL same_pre_rd2 idx=%0d got=%h exp=%h", idx[k], bus.readData2, exp_pre);
      end
      tick();
      bus.writeEnable = 1'b0;
      #1;
      checks++;
      if (bus.readData1 !== exp_post) begin
        errors++;
        $display("FAIL same_post_rd1 idx=%0d got=%h exp=%h", idx[k], bus.readData1, exp_post);
      end
      checks++;
      if (bus.readData2 !== exp_post) begin
        errors++;
        $display("FAIL same_post_rd2 idx=%0d got=%h exp=%h", idx[k], bus.readData2, exp_post);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Consecutive writes to neighbouring registers, then independent reads.
    bus.writeEnable = 1'b1;
    bus.wrReg       = 5'd10;
    bus.wrData      = 32'hA5A5_0001;
    tick();
    bus.wrReg       = 5'd11;
    bus.wrData      = 32'h5A5A_0002;
    tick();
    bus.wrReg       = 5'd10;
    bus.wrData      = 32'h1234_5678;
    tick();
    bus.writeEnable = 1'b0;
    bus.readSelect1 = 5'd10;
    bus.readSelect2 = 5'd11;
    #1;
    checks++;
    if (bus.readData1 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL b2b_reg10 got=%h exp=%h", bus.readData1, 32'h1234_5678);
    end
    checks++;
    if (bus.readData2 !== 32'h5A5A_0002) begin
      errors++;
      $display("FAIL b2b_reg11 got=%h exp=%h", bus.readData2, 32'h5A5A_0002);
    end
    bus.readSelect1 = 5'd12;
    #1;
    checks++;
    if (bus.readData1 !== 32'h0) begin
      errors++;
      $display("FAIL b2b_reg12 got=%h exp=%h", bus.readData1, 32'h0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_sweep();
    test_x0();
    test_write_enable_gate();
    test_reset_priority();
    test_same_index();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
